// File: rtl/sysreset_pkg.sv
// rtl/sysreset_pkg.sv - shared encodings for the system reset request block
package sysreset_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_BTN  = 2'b01,
        CAUSE_WDT  = 2'b10,
        CAUSE_SW   = 2'b11
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ASSERT  = 2'b01,
        ST_HOLDOFF = 2'b10
    } state_e;

endpackage

// File: rtl/sysreset_debounce.sv
// rtl/sysreset_debounce.sv - button synchronizer, debouncer and rising-edge pulse
module sysreset_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pad_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronized pad disagrees with the accepted level
    always_comb begin
        sync_d  = {sync_q[0], pad_i};
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = ~level_q;
            cnt_d   = '0;
            rise_d  = ~level_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/sysreset_req.sv
// rtl/sysreset_req.sv - merges button, watchdog and software sources into one reset pulse
module sysreset_req
    import sysreset_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned PULSE_LEN       = 16,
    parameter int unsigned HOLDOFF_CYCLES  = 1048576,
    parameter int unsigned WDT_W           = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             btn_pad,
    input  logic             sw_reset_req,
    input  logic             wdt_enable,
    input  logic             wdt_kick,
    input  logic [WDT_W-1:0] wdt_timeout,
    output logic             trigger_reset,
    output logic [1:0]       reset_cause,
    output logic [WDT_W-1:0] wdt_count,
    output logic             busy
);

    localparam int unsigned CNT_TOP = (HOLDOFF_CYCLES > PULSE_LEN) ? HOLDOFF_CYCLES : PULSE_LEN;
    localparam int unsigned CNT_W   = $clog2(CNT_TOP + 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_CYCLES - 1);

    logic btn_level, btn_rise;

    sysreset_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .pad_i  (btn_pad),
        .level_o(btn_level),
        .rise_o (btn_rise)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cause_e           cause_q, cause_d;
    logic             trig_q, busy_q;

    logic             wdt_en_q, wdt_block_q, wdt_block_d, wdt_req_q, wdt_req_d, wdt_rise;
    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;

    // Holdoff parks the watchdog at zero; only a new enable edge re-arms it
    always_comb begin
        wdt_rise    = wdt_enable & ~wdt_en_q;
        wdt_cnt_d   = wdt_cnt_q;
        wdt_block_d = wdt_block_q;
        wdt_req_d   = 1'b0;
        if (state_q == ST_HOLDOFF) begin
            wdt_cnt_d   = '0;
            wdt_block_d = 1'b1;
        end else if (wdt_rise) begin
            wdt_cnt_d   = wdt_timeout;
            wdt_block_d = 1'b0;
        end else if (wdt_enable && !wdt_block_q) begin
            if (wdt_kick) begin
                wdt_cnt_d = wdt_timeout;
            end else if (wdt_cnt_q != '0) begin
                wdt_cnt_d = wdt_cnt_q - WDT_W'(1);
                wdt_req_d = (wdt_cnt_q == WDT_W'(1));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_rise || wdt_req_q || sw_reset_req) begin
                    state_d = ST_ASSERT;
                    cnt_d   = PULSE_LOAD;
                    if (btn_rise)       cause_d = CAUSE_BTN;
                    else if (wdt_req_q) cause_d = CAUSE_WDT;
                    else                cause_d = CAUSE_SW;
                end
            end
            ST_ASSERT: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q != '0)     cnt_d   = cnt_q - CNT_W'(1);
                else if (!btn_level) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cause_q     <= CAUSE_NONE;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            wdt_en_q    <= 1'b0;
            wdt_block_q <= 1'b0;
            wdt_req_q   <= 1'b0;
            wdt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cause_q     <= cause_d;
            trig_q      <= (state_d == ST_ASSERT);
            busy_q      <= (state_d != ST_IDLE);
            wdt_en_q    <= wdt_enable;
            wdt_block_q <= wdt_block_d;
            wdt_req_q   <= wdt_req_d;
            wdt_cnt_q   <= wdt_cnt_d;
        end
    end

    assign trigger_reset = trig_q;
    assign reset_cause   = cause_q;
    assign wdt_count     = wdt_cnt_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_sysreset_req.sv
// tb/tb_sysreset_req.sv - self-checking bench for sysreset_req
module tb_sysreset_req;
    import sysreset_pkg::*;

    localparam int DB = 8;
    localparam int PL = 4;
    localparam int HO = 10;
    localparam int WW = 8;

    logic          sys_clk      = 1'b0;
    logic          sys_rst_n    = 1'b0;
    logic          btn_pad      = 1'b0;
    logic          sw_reset_req = 1'b0;
    logic          wdt_enable   = 1'b0;
    logic          wdt_kick     = 1'b0;
    logic [WW-1:0] wdt_timeout  = '0;
    logic          trigger_reset;
    logic [1:0]    reset_cause;
    logic [WW-1:0] wdt_count;
    logic          busy;

    sysreset_req #(
        .DEBOUNCE_CYCLES(DB),
        .PULSE_LEN      (PL),
        .HOLDOFF_CYCLES (HO),
        .WDT_W          (WW)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .btn_pad      (btn_pad),
        .sw_reset_req (sw_reset_req),
        .wdt_enable   (wdt_enable),
        .wdt_kick     (wdt_kick),
        .wdt_timeout  (wdt_timeout),
        .trigger_reset(trigger_reset),
        .reset_cause  (reset_cause),
        .wdt_count    (wdt_count),
        .busy         (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] cause;
        int         start;
    } pulse_t;

    typedef struct {
        logic          kick;
        logic [WW-1:0] exp_cnt;
    } wdt_vec_t;

    pulse_t   sbq[$];
    pulse_t   exp_p;
    wdt_vec_t wv[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            step();
            n++;
        end
        check("idle_within_bound", busy, 0);
    endtask

    logic trig_prev = 1'b0;
    int   width     = 0;

    // Each observed pulse is matched against the oldest expected pulse
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            trig_prev = 1'b0;
            width     = 0;
        end else begin
            if (trigger_reset && !trig_prev) begin
                check("pulse_expected", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    exp_p = sbq.pop_front();
                    check("pulse_start_cycle", cyc, exp_p.start);
                    check("pulse_cause", reset_cause, exp_p.cause);
                end
                width = 1;
            end else if (trigger_reset) begin
                width++;
            end else if (trig_prev) begin
                check("pulse_width", width, PL);
            end
            trig_prev = trigger_reset;
        end
    end

    initial begin
        wv = '{'{1'b0, 8'd5}, '{1'b0, 8'd4}, '{1'b0, 8'd3}, '{1'b0, 8'd2}, '{1'b1, 8'd5},
               '{1'b0, 8'd4}, '{1'b0, 8'd3}, '{1'b0, 8'd2}, '{1'b0, 8'd1}, '{1'b0, 8'd0}};

        // power-on
        sys_rst_n = 1'b0;
        step(3);
        check("reset_outputs", {trigger_reset, reset_cause, busy, wdt_count}, 0);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            check("por_idle", {trigger_reset, reset_cause, busy}, 0);
        end

        // bouncy then stable button, held through holdoff
        for (int i = 0; i < 10; i++) begin
            btn_pad = ~btn_pad;
            step(3);
        end
        check("bounce_no_busy", busy, 0);
        btn_pad = 1'b1;
        sbq.push_back('{CAUSE_BTN, cyc + 2 + DB + 1});
        step(2 + DB + 1 + PL);
        check("btn_cause", reset_cause, CAUSE_BTN);
        step(HO + 10);
        check("held_btn_busy", busy, 1);
        btn_pad = 1'b0;
        step(2 + DB);
        check("release_not_yet_idle", busy, 1);
        step();
        check("release_idle", busy, 0);
        check("btn_cause_sticky", reset_cause, CAUSE_BTN);

        // watchdog with one kick, then expiry
        wdt_timeout = 8'd5;
        wdt_enable  = 1'b1;
        sbq.push_back('{CAUSE_WDT, cyc + 11});
        for (int i = 0; i < 10; i++) begin
            wdt_kick = wv[i].kick;
            step();
            check("wdt_count_seq", wdt_count, wv[i].exp_cnt);
        end
        wdt_kick = 1'b0;
        step(PL + 1);
        check("wdt_cause", reset_cause, CAUSE_WDT);
        wait_idle(30);
        wdt_kick = 1'b1;
        step();
        wdt_kick = 1'b0;
        step();
        check("blocked_after_holdoff", wdt_count, 0);

        // software and watchdog in the same cycle, then software during holdoff
        wdt_enable = 1'b0;
        step();
        wdt_timeout = 8'd3;
        wdt_enable  = 1'b1;
        step();
        check("wdt_rearm_load", wdt_count, 3);
        step(3);
        check("wdt_expired", wdt_count, 0);
        sw_reset_req = 1'b1;
        sbq.push_back('{CAUSE_WDT, cyc + 1});
        step();
        sw_reset_req = 1'b0;
        step(PL);
        check("coincide_cause", reset_cause, CAUSE_WDT);
        step(2);
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        check("holdoff_busy", busy, 1);
        wait_idle(30);
        step(5);
        check("no_second_pulse", sbq.size(), 0);
        check("coincide_cause_sticky", reset_cause, CAUSE_WDT);

        // power-on reset in the middle of a pulse
        wdt_enable = 1'b0;
        step();
        sw_reset_req = 1'b1;
        sbq.push_back('{CAUSE_SW, cyc + 1});
        step();
        sw_reset_req = 1'b0;
        step();
        check("assert_second_cycle", trigger_reset, 1);
        sys_rst_n = 1'b0;
        #1;
        check("async_drop", {trigger_reset, reset_cause, busy}, 0);
        step(2);
        sys_rst_n = 1'b1;
        step(2);
        sw_reset_req = 1'b1;
        sbq.push_back('{CAUSE_SW, cyc + 1});
        step();
        sw_reset_req = 1'b0;
        step(PL);
        check("sw_cause", reset_cause, CAUSE_SW);
        wait_idle(30);
        check("queue_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
